id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage RISC-V core; sits directly upstream of the EX-stage ALU.
//  Captures decoded control, register operands, immediate, funct bits and register addresses.
//  Presents them to ALU_Control, the ALU-input muxes and the forwarding unit one cycle later.
//  Supports stall (hold) and flush (bubble insertion) for hazard handling.
// PARAMETERS
//  DATA_W      32  width of register operands and immediate
//  RADDR_W     5   width of register addresses
//  CNT_W       32  width of performance counters (only with IDEX_PERF_CNT_EN)
// PORTS
//  clk_i             in   1        core clock, all state updates on posedge
//  rst_i             in   1        synchronous, active-high reset
//  stall_i           in   1        hold current contents
//  flush_i           in   1        load a bubble
//  valid_i           in   1        ID stage holds a real instruction
//  RegWrite_i/_o     in/out 1      register-file write enable
//  MemtoReg_i/_o     in/out 1      writeback source select
//  MemRead_i/_o      in/out 1      data-memory read
//  MemWrite_i/_o     in/out 1      data-memory write
//  ALUOp_i/_o        in/out 2      ALU op class for ALU_Control
//  ALUSrc_i/_o       in/out 1      ALU operand-2 select (1 = immediate)
//  RS1data_i/_o      in/out DATA_W rs1 read data
//  RS2data_i/_o      in/out DATA_W rs2 read data
//  imm_i/_o          in/out DATA_W sign-extended immediate
//  funct_i/_o        in/out 10     {funct7, funct3} for ALU_Control
//  RS1addr_i/_o      in/out RADDR_W rs1 index, for forwarding
//  RS2addr_i/_o      in/out RADDR_W rs2 index, for forwarding
//  RDaddr_i/_o       in/out RADDR_W destination index
//  valid_o           out  1        EX stage holds a real instruction
//  stall_cnt_o       out  CNT_W    cycles held by stall (IDEX_PERF_CNT_EN only)
//  bubble_cnt_o      out  CNT_W    bubbles inserted by flush (IDEX_PERF_CNT_EN only)
// BEHAVIOUR
//  - All outputs are registered; latency from *_i to *_o is 1 cycle. No combinational path in to out.
//  - Update priority on each posedge clk_i: rst_i > flush_i > stall_i > load.
//  - rst_i: every output cleared to 0, including valid_o and the counters.
//  - flush_i: a bubble is loaded. All outputs become 0 and valid_o becomes 0.
//    A bubble is equal to "addi x0,x0,0" with no write, since RegWrite/MemRead/MemWrite are 0.
//  - flush_i and stall_i together: flush wins, so a bubble is loaded.
//  - stall_i alone: every output holds its value, including valid_o.
//  - Load (no rst/flush/stall): every *_o takes its *_i, and valid_o takes valid_i.
//  - valid_i=0 on load: fields are still captured, but RegWrite_o, MemRead_o and MemWrite_o are forced to 0.
//    This keeps an invalid slot from producing side effects.
//  - RDaddr_i==0 on load: RegWrite_o is forced to 0, because x0 is never written.
//  - Reset asserted mid-stall or mid-flush: reset wins and takes effect on that same edge.
// CONFIGURATION
//  IDEX_PERF_CNT_EN defined:
//   - stall_cnt_o increments on each edge where stall_i=1 and neither flush_i nor rst_i is asserted.
//   - bubble_cnt_o increments on each edge where flush_i=1 and rst_i is not asserted.
//   - Both counters saturate at 2^CNT_W-1 (no wrap). Both clear on rst_i.
//  IDEX_PERF_CNT_EN undefined:
//   - The counter ports and their logic are absent.
//   - All other behaviour is identical.
// TESTING
//  1 rst_i=1 for 2 cycles with all inputs at 1 -> every output 0, including valid_o=0.
//  2 Load RS1data_i=32'h0000_0005, imm_i=32'hFFFF_FFFC, ALUSrc_i=1, RDaddr_i=3, RegWrite_i=1, valid_i=1
//    -> the next cycle shows the same values on the outputs.
//  3 After scenario 2, hold stall_i=1 for 3 cycles while changing the inputs
//    -> outputs stay unchanged; stall_cnt_o=3 (with EN).
//  4 stall_i=1 and flush_i=1 together -> all outputs 0, valid_o=0; bubble_cnt_o+1, stall_cnt_o unchanged.
//  5 Load RegWrite_i=1, RDaddr_i=0, valid_i=1 -> RegWrite_o=0.
//    Load MemWrite_i=1, valid_i=0 -> MemWrite_o=0.
//  6 Preload counters to 2^CNT_W-2 and apply 3 flushes -> bubble_cnt_o=2^CNT_W-1 (saturated).

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded control and operands for EX, with stall/flush support.
// Optional stall/bubble performance counters are built when IDEX_PERF_CNT_EN is defined.
module id_ex_pipeline_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
`ifdef IDEX_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic               RegWrite_i,
    input  logic               MemtoReg_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic [1:0]         ALUOp_i,
    input  logic               ALUSrc_i,
    input  logic [DATA_W-1:0]  RS1data_i,
    input  logic [DATA_W-1:0]  RS2data_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [9:0]         funct_i,
    input  logic [RADDR_W-1:0] RS1addr_i,
    input  logic [RADDR_W-1:0] RS2addr_i,
    input  logic [RADDR_W-1:0] RDaddr_i,
    output logic               RegWrite_o,
    output logic               MemtoReg_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic [1:0]         ALUOp_o,
    output logic               ALUSrc_o,
    output logic [DATA_W-1:0]  RS1data_o,
    output logic [DATA_W-1:0]  RS2data_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [9:0]         funct_o,
    output logic [RADDR_W-1:0] RS1addr_o,
    output logic [RADDR_W-1:0] RS2addr_o,
    output logic [RADDR_W-1:0] RDaddr_o,
    output logic               valid_o
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
`endif
);

    logic               reg_write_reg;
    logic               mem_to_reg_reg;
    logic               mem_read_reg;
    logic               mem_write_reg;
    logic [1:0]         alu_op_reg;
    logic               alu_src_reg;
    logic [DATA_W-1:0]  rs1_data_reg;
    logic [DATA_W-1:0]  rs2_data_reg;
    logic [DATA_W-1:0]  imm_reg;
    logic [9:0]         funct_reg;
    logic [RADDR_W-1:0] rs1_addr_reg;
    logic [RADDR_W-1:0] rs2_addr_reg;
    logic [RADDR_W-1:0] rd_addr_reg;
    logic               valid_reg;

    // Side-effecting controls are suppressed for invalid slots; x0 is never a write target.
    logic reg_write_next;
    logic mem_read_next;
    logic mem_write_next;

    always_comb begin
        reg_write_next = RegWrite_i & valid_i & (RDaddr_i != '0);
        mem_read_next  = MemRead_i & valid_i;
        mem_write_next = MemWrite_i & valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            alu_op_reg     <= '0;
            alu_src_reg    <= 1'b0;
            rs1_data_reg   <= '0;
            rs2_data_reg   <= '0;
            imm_reg        <= '0;
            funct_reg      <= '0;
            rs1_addr_reg   <= '0;
            rs2_addr_reg   <= '0;
            rd_addr_reg    <= '0;
            valid_reg      <= 1'b0;
        end else if (!stall_i) begin
            reg_write_reg  <= reg_write_next;
            mem_to_reg_reg <= MemtoReg_i;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            alu_op_reg     <= ALUOp_i;
            alu_src_reg    <= ALUSrc_i;
            rs1_data_reg   <= RS1data_i;
            rs2_data_reg   <= RS2data_i;
            imm_reg        <= imm_i;
            funct_reg      <= funct_i;
            rs1_addr_reg   <= RS1addr_i;
            rs2_addr_reg   <= RS2addr_i;
            rd_addr_reg    <= RDaddr_i;
            valid_reg      <= valid_i;
        end
    end

    assign RegWrite_o = reg_write_reg;
    assign MemtoReg_o = mem_to_reg_reg;
    assign MemRead_o  = mem_read_reg;
    assign MemWrite_o = mem_write_reg;
    assign ALUOp_o    = alu_op_reg;
    assign ALUSrc_o   = alu_src_reg;
    assign RS1data_o  = rs1_data_reg;
    assign RS2data_o  = rs2_data_reg;
    assign imm_o      = imm_reg;
    assign funct_o    = funct_reg;
    assign RS1addr_o  = rs1_addr_reg;
    assign RS2addr_o  = rs2_addr_reg;
    assign RDaddr_o   = rd_addr_reg;
    assign valid_o    = valid_reg;

`ifdef IDEX_PERF_CNT_EN
    // Index 0 counts held cycles (a flush overrides the stall), index 1 counts inserted bubbles.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc[0] = stall_i & ~flush_i;
    assign cnt_inc[1] = flush_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt_o  = cnt_reg[0];
    assign bubble_cnt_o = cnt_reg[1];
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg; expected outputs are queued at drive time and
// checked one cycle later. Counter checks are built when IDEX_PERF_CNT_EN is defined.
module tb_id_ex_pipeline_reg;

    localparam int TB_CNT_W = 4;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic [1:0]  aluop;
        logic        alusrc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
        logic        valid;
    } fields_t;

    typedef struct packed {
        logic    rst;
        logic    flush;
        logic    stall;
        fields_t f;
    } stim_t;

    logic    clk;
    stim_t   cur;
    fields_t obs;
    fields_t model;
    fields_t exp_q[$];
    int      total;
    int      bad;

`ifdef IDEX_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] bubble_cnt;
    logic [TB_CNT_W-1:0] m_stall_cnt;
    logic [TB_CNT_W-1:0] m_bubble_cnt;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_ex_pipeline_reg #(
        .DATA_W (32),
        .RADDR_W(5)
`ifdef IDEX_PERF_CNT_EN
        , .CNT_W(TB_CNT_W)
`endif
    ) dut (
        .clk_i     (clk),
        .rst_i     (cur.rst),
        .stall_i   (cur.stall),
        .flush_i   (cur.flush),
        .valid_i   (cur.f.valid),
        .RegWrite_i(cur.f.rw),
        .MemtoReg_i(cur.f.m2r),
        .MemRead_i (cur.f.mr),
        .MemWrite_i(cur.f.mw),
        .ALUOp_i   (cur.f.aluop),
        .ALUSrc_i  (cur.f.alusrc),
        .RS1data_i (cur.f.rs1),
        .RS2data_i (cur.f.rs2),
        .imm_i     (cur.f.imm),
        .funct_i   (cur.f.funct),
        .RS1addr_i (cur.f.rs1a),
        .RS2addr_i (cur.f.rs2a),
        .RDaddr_i  (cur.f.rda),
        .RegWrite_o(obs.rw),
        .MemtoReg_o(obs.m2r),
        .MemRead_o (obs.mr),
        .MemWrite_o(obs.mw),
        .ALUOp_o   (obs.aluop),
        .ALUSrc_o  (obs.alusrc),
        .RS1data_o (obs.rs1),
        .RS2data_o (obs.rs2),
        .imm_o     (obs.imm),
        .funct_o   (obs.funct),
        .RS1addr_o (obs.rs1a),
        .RS2addr_o (obs.rs2a),
        .RDaddr_o  (obs.rda),
        .valid_o   (obs.valid)
`ifdef IDEX_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt),
        .bubble_cnt_o(bubble_cnt)
`endif
    );

    function automatic fields_t rand_fields();
        fields_t r;
        r.rw     = 1'($urandom);
        r.m2r    = 1'($urandom);
        r.mr     = 1'($urandom);
        r.mw     = 1'($urandom);
        r.aluop  = 2'($urandom);
        r.alusrc = 1'($urandom);
        r.rs1    = $urandom;
        r.rs2    = $urandom;
        r.imm    = $urandom;
        r.funct  = 10'($urandom);
        r.rs1a   = 5'($urandom);
        r.rs2a   = 5'($urandom);
        r.rda    = 5'($urandom);
        r.valid  = 1'($urandom);
        return r;
    endfunction

    // Drive one cycle of stimulus, queue the expected outputs, then check after the edge.
    task automatic step(input stim_t s, input string tag);
        fields_t e;
        cur = s;
        if (s.rst) begin
            model = '0;
`ifdef IDEX_PERF_CNT_EN
            m_stall_cnt  = '0;
            m_bubble_cnt = '0;
`endif
        end else if (s.flush) begin
            model = '0;
`ifdef IDEX_PERF_CNT_EN
            if (m_bubble_cnt != {TB_CNT_W{1'b1}}) m_bubble_cnt = m_bubble_cnt + 1'b1;
`endif
        end else if (s.stall) begin
`ifdef IDEX_PERF_CNT_EN
            if (m_stall_cnt != {TB_CNT_W{1'b1}}) m_stall_cnt = m_stall_cnt + 1'b1;
`endif
        end else begin
            model    = s.f;
            model.rw = s.f.rw && s.f.valid && (s.f.rda != 5'd0);
            model.mr = s.f.mr && s.f.valid;
            model.mw = s.f.mw && s.f.valid;
        end
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: outputs got %h want %h", tag, obs, e);
        end
`ifdef IDEX_PERF_CNT_EN
        total++;
        assert (stall_cnt === m_stall_cnt) else begin
            bad++;
            $error("FAIL %s_stall_cnt: got %0d want %0d", tag, stall_cnt, m_stall_cnt);
        end
        total++;
        assert (bubble_cnt === m_bubble_cnt) else begin
            bad++;
            $error("FAIL %s_bubble_cnt: got %0d want %0d", tag, bubble_cnt, m_bubble_cnt);
        end
`endif
        $display("txn %s: valid_o=%0d RegWrite_o=%0d RDaddr_o=%0d", tag, obs.valid, obs.rw, obs.rda);
    endtask

    initial begin
        stim_t s;
        fields_t held;
        total = 0;
        bad   = 0;
        model = '0;
`ifdef IDEX_PERF_CNT_EN
        m_stall_cnt  = '0;
        m_bubble_cnt = '0;
`endif
        // Reset with every input at 1.
        s = '1;
        step(s, "reset0");
        step(s, "reset1");
        total++;
        assert (obs === '0) else begin
            bad++;
            $error("FAIL reset_all_zero: got %h want 0", obs);
        end

        // Basic load.
        s = '0;
        s.f.rs1    = 32'h0000_0005;
        s.f.imm    = 32'hFFFF_FFFC;
        s.f.alusrc = 1'b1;
        s.f.rda    = 5'd3;
        s.f.rw     = 1'b1;
        s.f.valid  = 1'b1;
        step(s, "load_basic");
        total++;
        assert (obs.imm === 32'hFFFF_FFFC && obs.rw === 1'b1 && obs.rda === 5'd3) else begin
            bad++;
            $error("FAIL load_basic_fields: got imm=%h rw=%0d rd=%0d want imm=fffffffc rw=1 rd=3",
                   obs.imm, obs.rw, obs.rda);
        end
        held = obs;

        // Stall for 3 cycles while inputs change.
        for (int i = 0; i < 3; i++) begin
            s = '0;
            s.f = rand_fields();
            s.stall = 1'b1;
            step(s, $sformatf("stall%0d", i));
        end
        total++;
        assert (obs === held) else begin
            bad++;
            $error("FAIL stall_hold: got %h want %h", obs, held);
        end
`ifdef IDEX_PERF_CNT_EN
        total++;
        assert (stall_cnt === 4'd3) else begin
            bad++;
            $error("FAIL stall_cnt_3: got %0d want 3", stall_cnt);
        end
`endif

        // Stall and flush together.
        s = '0;
        s.f = rand_fields();
        s.stall = 1'b1;
        s.flush = 1'b1;
        step(s, "stall_flush");
        total++;
        assert (obs === '0) else begin
            bad++;
            $error("FAIL stall_flush_bubble: got %h want 0", obs);
        end

        // RegWrite to x0 suppressed; invalid slot MemWrite suppressed.
        s = '0;
        s.f.rw = 1'b1;
        s.f.rda = 5'd0;
        s.f.valid = 1'b1;
        s.f.rs2 = 32'hCAFE_0001;
        step(s, "rd_x0");
        total++;
        assert (obs.rw === 1'b0) else begin
            bad++;
            $error("FAIL rd_x0_regwrite: got %0d want 0", obs.rw);
        end
        s = '0;
        s.f.mw = 1'b1;
        s.f.mr = 1'b1;
        s.f.rw = 1'b1;
        s.f.rda = 5'd7;
        s.f.valid = 1'b0;
        s.f.funct = 10'h2A5;
        step(s, "invalid_slot");
        total++;
        assert (obs.mw === 1'b0 && obs.funct === 10'h2A5) else begin
            bad++;
            $error("FAIL invalid_memwrite: got mw=%0d funct=%h want mw=0 funct=2a5", obs.mw, obs.funct);
        end

        // Mixed random loads, stalls and flushes.
        for (int i = 0; i < 16; i++) begin
            s = '0;
            s.f = rand_fields();
            s.stall = ($urandom_range(0, 3) == 0);
            s.flush = ($urandom_range(0, 5) == 0);
            step(s, $sformatf("mix%0d", i));
        end

        // Reset during stall+flush wins on that edge.
        s = '0;
        s.f = rand_fields();
        s.f.valid = 1'b1;
        step(s, "preload");
        s = '1;
        step(s, "rst_mid");

`ifdef IDEX_PERF_CNT_EN
        // Drive both counters to saturation.
        for (int i = 0; i < (1 << TB_CNT_W) + 2; i++) begin
            s = '0;
            s.flush = 1'b1;
            step(s, $sformatf("flush_sat%0d", i));
        end
        total++;
        assert (bubble_cnt === {TB_CNT_W{1'b1}}) else begin
            bad++;
            $error("FAIL bubble_saturate: got %0d want %0d", bubble_cnt, {TB_CNT_W{1'b1}});
        end
        for (int i = 0; i < (1 << TB_CNT_W) + 2; i++) begin
            s = '0;
            s.stall = 1'b1;
            step(s, $sformatf("stall_sat%0d", i));
        end
        total++;
        assert (stall_cnt === {TB_CNT_W{1'b1}}) else begin
            bad++;
            $error("FAIL stall_saturate: got %0d want %0d", stall_cnt, {TB_CNT_W{1'b1}});
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
